// File: rtl/fpu_pkg.sv
// Shared opcodes, sequencer states and per-stage control payload for the FPU issue sequencer.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_PIPE     = 2'd0,
        ST_DIV_ITER = 2'd1,
        ST_DIV_DONE = 2'd2
    } seqState_t;

    typedef struct packed {
        logic [1:0] op;
        logic       effOperation;
        logic       exclusiveSign;
    } stageCtl_t;

    // Sign-control decode: effective operation only meaningful for ADD/SUB.
    function automatic stageCtl_t decodeIssue(input logic [1:0] op, input logic signX,
                                              input logic signY);
        stageCtl_t c;
        c.op            = op;
        c.exclusiveSign = signX ^ signY;
        c.effOperation  = (op == OP_ADD || op == OP_SUB) ?
                          (c.exclusiveSign ^ (op == OP_SUB)) : 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/fpu_addsub_sequencer_if.sv
// Request/response and datapath-control bundle between the sequencer and its neighbours.
interface fpu_addsub_sequencer_if #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 4
);
    logic                           ReqValid;
    logic                           ReqReady;
    logic [1:0]                     ReqOp;
    logic                           ReqSignX;
    logic                           ReqSignY;
    logic [TAG_W-1:0]               ReqTag;
    logic                           Flush;
    logic [STAGES-1:0]              StageEn;
    logic                           DivIterEn;
    logic                           DivStart;
    logic                           SignEffOperation;
    logic                           SignExclusiveSign;
    logic                           RespValid;
    logic                           RespReady;
    logic [1:0]                     RespOp;
    logic [TAG_W-1:0]               RespTag;
    logic [$clog2(STAGES+1)-1:0]    InFlight;

    modport master (
        output ReqValid, ReqOp, ReqSignX, ReqSignY, ReqTag, Flush, RespReady,
        input  ReqReady, StageEn, DivIterEn, DivStart, SignEffOperation, SignExclusiveSign,
               RespValid, RespOp, RespTag, InFlight
    );

    modport slave (
        input  ReqValid, ReqOp, ReqSignX, ReqSignY, ReqTag, Flush, RespReady,
        output ReqReady, StageEn, DivIterEn, DivStart, SignEffOperation, SignExclusiveSign,
               RespValid, RespOp, RespTag, InFlight
    );

endinterface

// File: rtl/fpu_pipe_ctrl.sv
// Valid/advance chain plus op/tag/sign control shift register for the ADD/SUB/MUL pipe.
module fpu_pipe_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned STAGES = 4,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              flush,
    input  logic              respReady,
    input  logic              loadValid,
    input  stageCtl_t         loadCtl,
    input  logic [TAG_W-1:0]  loadTag,
    output logic [STAGES-1:0] adv,
    output logic [STAGES-1:0] valid,
    output stageCtl_t         ctl [STAGES],
    output logic [TAG_W-1:0]  tag [STAGES]
);

    // A stage may advance when it is empty or everything downstream moves.
    always_comb begin
        logic down;
        adv             = '0;
        down            = ~valid[STAGES-1] | respReady;
        adv[STAGES-1]   = down;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            down   = ~valid[i] | down;
            adv[i] = down;
        end
    end

    // Shift valid bits and control payload forward on each stage enable.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            valid <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                ctl[i] <= '0;
                tag[i] <= '0;
            end
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (adv[0]) begin
                valid[0] <= loadValid;
                ctl[0]   <= loadCtl;
                tag[0]   <= loadTag;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (adv[i]) begin
                    valid[i] <= valid[i-1];
                    ctl[i]   <= ctl[i-1];
                    tag[i]   <= tag[i-1];
                end
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_sequencer.sv
// Issue controller: pipelines ADD/SUB/MUL, runs DIV exclusively under a small FSM.
module fpu_addsub_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned STAGES     = 4,
    parameter int unsigned SIGN_STAGE = 1,
    parameter int unsigned DIV_CYCLES = 24,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                   Clk,
    input  logic                   ResetN,
    fpu_addsub_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
    localparam int unsigned IF_W  = $clog2(STAGES + 1);

    seqState_t         state;
    logic [CNT_W-1:0]  divCnt;
    logic [TAG_W-1:0]  divTag;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] valid;
    stageCtl_t         ctl [STAGES];
    logic [TAG_W-1:0]  tag [STAGES];
    stageCtl_t         issueCtl;
    logic              reqIsDiv;
    logic              reqReady;
    logic              pipeLoad;
    logic              divAccept;
    logic [IF_W-1:0]   inFlightCnt;

    assign issueCtl = decodeIssue(bus.ReqOp, bus.ReqSignX, bus.ReqSignY);

    // Accept decision: DIV waits for an empty pipe; nothing is accepted while flushing or in reset.
    always_comb begin
        reqIsDiv = (bus.ReqOp == OP_DIV);
        reqReady = 1'b0;
        if (ResetN && state == ST_PIPE && !bus.Flush) begin
            reqReady = reqIsDiv ? (valid == '0) : adv[0];
        end
        pipeLoad  = bus.ReqValid & reqReady & ~reqIsDiv;
        divAccept = bus.ReqValid & reqReady & reqIsDiv;
    end

    fpu_pipe_ctrl #(
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) u_pipe (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .flush     (bus.Flush),
        .respReady (bus.RespReady),
        .loadValid (pipeLoad),
        .loadCtl   (issueCtl),
        .loadTag   (bus.ReqTag),
        .adv       (adv),
        .valid     (valid),
        .ctl       (ctl),
        .tag       (tag)
    );

    // DIV sequencing: load counter on accept, count down, hold result until taken.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state  <= ST_PIPE;
            divCnt <= '0;
            divTag <= '0;
        end else if (bus.Flush) begin
            state  <= ST_PIPE;
            divCnt <= '0;
        end else begin
            case (state)
                ST_PIPE: begin
                    if (divAccept) begin
                        state  <= ST_DIV_ITER;
                        divCnt <= CNT_W'(DIV_CYCLES - 1);
                        divTag <= bus.ReqTag;
                    end
                end
                ST_DIV_ITER: begin
                    if (divCnt == '0) begin
                        state <= ST_DIV_DONE;
                    end else begin
                        divCnt <= divCnt - CNT_W'(1);
                    end
                end
                ST_DIV_DONE: begin
                    if (bus.RespReady) begin
                        state <= ST_PIPE;
                    end
                end
                default: state <= ST_PIPE;
            endcase
        end
    end

    // Occupancy count of the pipe.
    always_comb begin
        inFlightCnt = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            inFlightCnt = inFlightCnt + IF_W'(valid[i]);
        end
    end

    // Output drive; the divider result takes the response port only in DIV_DONE.
    always_comb begin
        bus.ReqReady          = reqReady;
        bus.StageEn           = ResetN ? adv : '0;
        bus.DivIterEn         = (state == ST_DIV_ITER);
        bus.DivStart          = divAccept;
        bus.SignEffOperation  = valid[SIGN_STAGE] & ctl[SIGN_STAGE].effOperation;
        bus.SignExclusiveSign = valid[SIGN_STAGE] & ctl[SIGN_STAGE].exclusiveSign;
        bus.InFlight          = inFlightCnt;
        bus.RespValid         = 1'b0;
        bus.RespOp            = '0;
        bus.RespTag           = '0;
        if (state == ST_DIV_DONE) begin
            bus.RespValid = 1'b1;
            bus.RespOp    = OP_DIV;
            bus.RespTag   = divTag;
        end else if (state == ST_PIPE && valid[STAGES-1]) begin
            bus.RespValid = 1'b1;
            bus.RespOp    = ctl[STAGES-1].op;
            bus.RespTag   = tag[STAGES-1];
        end
    end

endmodule

// File: tb/tb_fpu_addsub_sequencer.sv
// Directed and randomized checks of the FPU issue sequencer against a transaction-level model.
module tb_fpu_addsub_sequencer;
    import fpu_pkg::*;

    localparam int STAGES     = 4;
    localparam int SIGN_STAGE = 1;
    localparam int DIV_CYCLES = 24;
    localparam int TAG_W      = 4;

    logic Clk = 1'b0;
    logic ResetN;

    always #5 Clk = ~Clk;

    fpu_addsub_sequencer_if #(.STAGES(STAGES), .TAG_W(TAG_W)) bus ();

    fpu_addsub_sequencer #(
        .STAGES     (STAGES),
        .SIGN_STAGE (SIGN_STAGE),
        .DIV_CYCLES (DIV_CYCLES),
        .TAG_W      (TAG_W)
    ) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .bus    (bus.slave)
    );

    // Ops accepted into the pipe, oldest first, with their accept cycle.
    typedef struct { int op; int tag; int acc; } pend_t;
    pend_t q[$];
    int    cyc;
    int    lastDep;
    int    divAcc;
    int    divTag;
    bit    divActive;
    bit    lastAcc;
    int    nTests;
    int    nFail;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", name, obs, exp, cyc);
        end
    endtask

    task automatic resetModel();
        q.delete();
        divActive = 1'b0;
        lastDep   = -100;
        lastAcc   = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input int tg, input bit sx,
                         input bit sy, input bit rr, input bit fl);
        bus.ReqValid  = v;
        bus.ReqOp     = op;
        bus.ReqTag    = TAG_W'(tg);
        bus.ReqSignX  = sx;
        bus.ReqSignY  = sy;
        bus.RespReady = rr;
        bus.Flush     = fl;
    endtask

    task automatic chkZero(input string name);
        chk({name, "_ReqReady"}, 32'(bus.ReqReady), 0);
        chk({name, "_StageEn"}, 32'(bus.StageEn), 0);
        chk({name, "_DivIterEn"}, 32'(bus.DivIterEn), 0);
        chk({name, "_DivStart"}, 32'(bus.DivStart), 0);
        chk({name, "_SignEff"}, 32'(bus.SignEffOperation), 0);
        chk({name, "_SignExcl"}, 32'(bus.SignExclusiveSign), 0);
        chk({name, "_RespValid"}, 32'(bus.RespValid), 0);
        chk({name, "_RespOp"}, 32'(bus.RespOp), 0);
        chk({name, "_RespTag"}, 32'(bus.RespTag), 0);
        chk({name, "_InFlight"}, 32'(bus.InFlight), 0);
    endtask

    // One clock: compare DUT against model, then advance the model at the edge.
    task automatic cycle();
        bit         expReady, expRespV, expIter, acc, xfer, isDiv, fl;
        int         expOp, expTag, tg;
        logic [1:0] op;
        #3;
        op    = bus.ReqOp;
        tg    = int'(bus.ReqTag);
        fl    = bus.Flush;
        isDiv = (op == OP_DIV);
        if (fl || divActive)          expReady = 1'b0;
        else if (isDiv)               expReady = (q.size() == 0);
        else                          expReady = !(q.size() == STAGES && !bus.RespReady);
        expRespV = 1'b0; expIter = 1'b0; expOp = 0; expTag = 0;
        if (divActive) begin
            expIter = (cyc <= divAcc + DIV_CYCLES);
            if (cyc > divAcc + DIV_CYCLES) begin
                expRespV = 1'b1; expOp = int'(OP_DIV); expTag = divTag;
            end
        end else if (q.size() != 0 && cyc >= q[0].acc + STAGES && cyc > lastDep) begin
            expRespV = 1'b1; expOp = q[0].op; expTag = q[0].tag;
        end
        acc  = bus.ReqValid && expReady;
        xfer = expRespV && bus.RespReady;
        chk("ReqReady", 32'(bus.ReqReady), 32'(expReady));
        chk("RespValid", 32'(bus.RespValid), 32'(expRespV));
        if (expRespV) begin
            chk("RespOp", 32'(bus.RespOp), 32'(expOp));
            chk("RespTag", 32'(bus.RespTag), 32'(expTag));
        end
        chk("DivIterEn", 32'(bus.DivIterEn), 32'(expIter));
        chk("DivStart", 32'(bus.DivStart), 32'(acc && isDiv));
        chk("InFlight", 32'(bus.InFlight), divActive ? 0 : 32'(q.size()));
        @(posedge Clk);
        if (xfer) begin
            if (divActive) divActive = 1'b0;
            else begin
                void'(q.pop_front());
                lastDep = cyc;
            end
        end
        if (acc) begin
            if (isDiv) begin
                divActive = 1'b1; divAcc = cyc; divTag = tg;
            end else begin
                q.push_back('{op: int'(op), tag: tg, acc: cyc});
            end
        end
        if (fl) begin
            q.delete();
            divActive = 1'b0;
        end
        lastAcc = acc;
        cyc++;
        #1;
    endtask

    initial begin
        int         n;
        int         iterCnt;
        int         startCnt;
        logic [1:0] rop;
        nTests = 0; nFail = 0; cyc = 0;
        resetModel();
        ResetN = 1'b0;
        drive(0, OP_ADD, 0, 0, 0, 0, 0);
        #2;
        chkZero("reset");
        #10 ResetN = 1'b1;
        @(posedge Clk); #1;

        // Back-to-back ADD/SUB/MUL: results at relative cycles 4,5,6.
        drive(1, OP_ADD, 1, 0, 0, 1, 0); cycle();
        drive(1, OP_SUB, 2, 0, 0, 1, 0); cycle();
        drive(1, OP_MUL, 3, 0, 0, 1, 0); cycle();
        drive(0, OP_ADD, 0, 0, 0, 1, 0);
        for (int k = 3; k < 8; k++) begin
            #2;
            chk("t1_RespValid", 32'(bus.RespValid), 32'(k >= 4 && k <= 6));
            if (k >= 4 && k <= 6) chk("t1_RespTag", 32'(bus.RespTag), 32'(k - 3));
            cycle();
        end

        // Sign control seen at stage 1.
        drive(1, OP_SUB, 4, 0, 0, 1, 0); cycle();
        drive(1, OP_ADD, 5, 1, 0, 1, 0); cycle();
        drive(0, OP_ADD, 0, 0, 0, 1, 0);
        #2;
        chk("t2_subEff", 32'(bus.SignEffOperation), 1);
        chk("t2_subExcl", 32'(bus.SignExclusiveSign), 0);
        cycle();
        #2;
        chk("t2_addEff", 32'(bus.SignEffOperation), 1);
        chk("t2_addExcl", 32'(bus.SignExclusiveSign), 1);
        cycle();
        repeat (5) cycle();

        // Fill under backpressure, then release.
        for (int k = 0; k < 4; k++) begin
            drive(1, 2'(k % 3), 6 + k, k[0], 0, 0, 0);
            cycle();
        end
        drive(1, OP_ADD, 10, 0, 0, 0, 0);
        #2;
        chk("t3_ReqReady", 32'(bus.ReqReady), 0);
        chk("t3_StageEn", 32'(bus.StageEn), 0);
        chk("t3_InFlight", 32'(bus.InFlight), 4);
        cycle();
        repeat (2) cycle();
        drive(0, OP_ADD, 0, 0, 0, 1, 0);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            #2;
            n += int'(bus.RespValid);
            cycle();
        end
        chk("t3_drainCount", 32'(n), 4);
        repeat (2) cycle();

        // DIV behind two ADDs.
        drive(1, OP_ADD, 1, 0, 1, 1, 0); cycle();
        drive(1, OP_ADD, 2, 1, 1, 1, 0); cycle();
        drive(1, OP_DIV, 11, 0, 1, 1, 0);
        n = 0; startCnt = 0; lastAcc = 1'b0;
        while (!lastAcc && n < 20) begin
            #2;
            startCnt += int'(bus.DivStart);
            cycle();
            n++;
        end
        drive(1, OP_ADD, 12, 0, 0, 0, 0);
        iterCnt = 0;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (bus.RespValid === 1'b1) break;
            iterCnt += int'(bus.DivIterEn);
            cycle();
        end
        chk("t4_DivStartCount", 32'(startCnt), 1);
        chk("t4_IterCount", 32'(iterCnt), 24);
        chk("t4_RespValid", 32'(bus.RespValid), 1);
        chk("t4_RespOp", 32'(bus.RespOp), 3);
        chk("t4_RespTag", 32'(bus.RespTag), 11);
        cycle();
        cycle();
        drive(0, OP_ADD, 0, 0, 0, 1, 0); cycle();
        #2;
        chk("t4_backToPipe", 32'(bus.ReqReady), 1);
        cycle();

        // Flush during DIV iteration.
        drive(1, OP_DIV, 13, 1, 1, 1, 0); cycle();
        drive(0, OP_ADD, 0, 0, 0, 1, 0);
        repeat (10) cycle();
        drive(0, OP_ADD, 0, 0, 0, 1, 1); cycle();
        drive(1, OP_ADD, 14, 0, 0, 1, 0);
        #2;
        chk("t5_IterOff", 32'(bus.DivIterEn), 0);
        chk("t5_ReadyAfterFlush", 32'(bus.ReqReady), 1);
        cycle();

        // Flush with three ops in flight.
        drive(1, OP_SUB, 15, 0, 1, 1, 0); cycle();
        drive(1, OP_MUL, 1, 1, 1, 1, 0); cycle();
        drive(0, OP_ADD, 0, 0, 0, 1, 1);
        #2;
        chk("t5_InFlightPre", 32'(bus.InFlight), 3);
        cycle();
        drive(1, OP_ADD, 2, 0, 0, 1, 0);
        #2;
        chk("t5_InFlightPost", 32'(bus.InFlight), 0);
        chk("t5_NoResp", 32'(bus.RespValid), 0);
        cycle();
        drive(0, OP_ADD, 0, 0, 0, 1, 0);
        repeat (6) cycle();

        // Asynchronous reset mid-stream.
        drive(1, OP_ADD, 3, 0, 0, 0, 0); cycle();
        drive(1, OP_MUL, 4, 1, 0, 0, 0); cycle();
        #2 ResetN = 1'b0;
        #1;
        chkZero("t6");
        @(posedge Clk); #1;
        ResetN = 1'b1;
        resetModel();
        drive(0, OP_ADD, 0, 0, 0, 1, 0);
        cycle();

        // Randomized traffic with occasional DIV and flush.
        for (int k = 0; k < 400; k++) begin
            rop = ($urandom_range(0, 7) == 0) ? OP_DIV : 2'($urandom_range(0, 2));
            drive($urandom_range(0, 3) != 0, rop, int'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
